// File: rtl/sync_fifo_v3_pkg.sv
// Shared helpers for the sync_fifo_v3 queue primitive.
// Pointer width is derived here so wrappers can size their status ports identically.
package sync_fifo_v3_pkg;

  function automatic int unsigned addr_bits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo_v3.sv
// Circular-buffer FIFO: 1-cycle write-to-head latency (0 with FALL_THROUGH); DEPTH=0 is pure pass-through.
// No internal backpressure beyond full_o/empty_o: pushes while full and pops while empty are dropped.
module sync_fifo_v3
  import sync_fifo_v3_pkg::*;
#(
  parameter logic        FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned ADDR_DEPTH   = addr_bits(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  dtype                  data_i,
  input  logic                  push_i,
  output dtype                  data_o,
  input  logic                  pop_i
);

  if (DEPTH == 0) begin : g_passthru
    assign data_o  = data_i;
    assign full_o  = !pop_i;
    assign empty_o = !push_i;
    assign usage_o = '0;
  end else begin : g_fifo
    localparam logic [ADDR_DEPTH:0]   FULL_CNT = (ADDR_DEPTH+1)'(DEPTH);
    localparam logic [ADDR_DEPTH-1:0] LAST_PTR = (ADDR_DEPTH)'(DEPTH - 1);

    logic [ADDR_DEPTH-1:0] read_ptr;
    logic [ADDR_DEPTH-1:0] write_ptr;
    logic [ADDR_DEPTH:0]   count;
    dtype                  mem [DEPTH];

    logic cnt_zero;
    logic ft_active;
    logic ft_bypass;
    logic push_acc;
    logic pop_acc;
    logic mem_en;

    assign cnt_zero  = (count == '0);
    assign ft_active = FALL_THROUGH && cnt_zero && push_i;
    // A simultaneous push+pop on an empty fall-through queue never touches storage.
    assign ft_bypass = ft_active && pop_i;

    assign full_o  = (count == FULL_CNT);
    assign empty_o = cnt_zero && !(FALL_THROUGH && push_i);
    assign usage_o = count[ADDR_DEPTH-1:0];
    assign data_o  = ft_active ? data_i : mem[read_ptr];

    assign push_acc = push_i && !full_o && !ft_bypass;
    assign pop_acc  = pop_i && !empty_o && !ft_bypass;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        read_ptr  <= '0;
        write_ptr <= '0;
        count     <= '0;
      end else if (flush_i) begin
        read_ptr  <= '0;
        write_ptr <= '0;
        count     <= '0;
      end else begin
        if (push_acc) begin
          write_ptr <= (write_ptr == LAST_PTR) ? '0 : write_ptr + 1'b1;
        end
        if (pop_acc) begin
          read_ptr <= (read_ptr == LAST_PTR) ? '0 : read_ptr + 1'b1;
        end
        if (push_acc && !pop_acc) begin
          count <= count + 1'b1;
        end else if (pop_acc && !push_acc) begin
          count <= count - 1'b1;
        end
      end
    end

    // Storage enable maps onto a clock gate; testmode_i holds the gate open and the
    // recirculating data path keeps contents unchanged.
    assign mem_en = push_acc || testmode_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          mem[i] <= '0;
        end
      end else if (mem_en) begin
        mem[write_ptr] <= push_acc ? data_i : mem[write_ptr];
      end
    end
  end

`ifndef SYNTHESIS
  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o))
    else $warning("sync_fifo_v3: push_i while full_o, entry dropped");
  a_no_underflow : assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && empty_o))
    else $warning("sync_fifo_v3: pop_i while empty_o, pop ignored");
`endif

endmodule

// File: tb/tb_sync_fifo_v3.sv
// Directed bench for sync_fifo_v3: DEPTH=4, DEPTH=4 fall-through, DEPTH=3 and DEPTH=0 instances.
module tb_sync_fifo_v3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       testmode = 1'b0;
  logic [7:0] din = 8'h00;

  logic       push_a = 1'b0, pop_a = 1'b0, full_a, empty_a;
  logic [1:0] usage_a;
  logic [7:0] dout_a;
  logic       push_f = 1'b0, pop_f = 1'b0, full_f, empty_f;
  logic [1:0] usage_f;
  logic [7:0] dout_f;
  logic       push_c = 1'b0, pop_c = 1'b0, full_c, empty_c;
  logic [1:0] usage_c;
  logic [7:0] dout_c;
  logic       push_p = 1'b0, pop_p = 1'b0, full_p, empty_p;
  logic [0:0] usage_p;
  logic [7:0] dout_p;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(4)) u_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .testmode_i(testmode),
    .full_o(full_a), .empty_o(empty_a), .usage_o(usage_a),
    .data_i(din), .push_i(push_a), .data_o(dout_a), .pop_i(pop_a));

  sync_fifo_v3 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(4)) u_f (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .testmode_i(testmode),
    .full_o(full_f), .empty_o(empty_f), .usage_o(usage_f),
    .data_i(din), .push_i(push_f), .data_o(dout_f), .pop_i(pop_f));

  sync_fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(3)) u_c (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .testmode_i(testmode),
    .full_o(full_c), .empty_o(empty_c), .usage_o(usage_c),
    .data_i(din), .push_i(push_c), .data_o(dout_c), .pop_i(pop_c));

  sync_fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(0)) u_p (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .testmode_i(testmode),
    .full_o(full_p), .empty_o(empty_p), .usage_o(usage_p),
    .data_i(din), .push_i(push_p), .data_o(dout_p), .pop_i(pop_p));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    push_a = 0; pop_a = 0; push_f = 0; pop_f = 0;
    push_c = 0; pop_c = 0; push_p = 0; pop_p = 0;
    flush = 0; testmode = 0; din = 8'h00;
    rst = 1;
    tick();
    rst = 0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1;
    #2;
    checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty_a); end
    checks++; if (full_a !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full_a); end
    checks++; if (usage_a !== 2'd0) begin errors++; $display("FAIL reset_usage got %0d want 0", usage_a); end
    checks++; if (dout_a !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", dout_a); end
    checks++; if (empty_f !== 1'b1) begin errors++; $display("FAIL reset_ft_empty got %b want 1", empty_f); end
    do_reset();
  endtask

  task automatic test_fill;
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      din = vals[i]; push_a = 1;
      tick();
      push_a = 0;
      #1;
      if (i == 0) begin
        checks++; if (dout_a !== 8'h11) begin errors++; $display("FAIL first_write_data got %h want 11", dout_a); end
        checks++; if (empty_a !== 1'b0) begin errors++; $display("FAIL first_write_empty got %b want 0", empty_a); end
      end
    end
    checks++; if (full_a !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", full_a); end
    checks++; if (usage_a !== 2'd0) begin errors++; $display("FAIL fill_usage got %0d want 0", usage_a); end
    din = 8'h55; push_a = 1;
    tick();
    push_a = 0;
    #1;
    checks++; if (full_a !== 1'b1) begin errors++; $display("FAIL overflow_full got %b want 1", full_a); end
    checks++; if (dout_a !== 8'h11) begin errors++; $display("FAIL overflow_head got %h want 11", dout_a); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (dout_a !== vals[i]) begin errors++; $display("FAIL drain_%0d got %h want %h", i, dout_a, vals[i]); end
      pop_a = 1;
      tick();
      pop_a = 0;
      #1;
    end
    checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", empty_a); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    testmode = 1;
    for (int i = 1; i <= 2; i++) begin
      din = 8'(i); push_a = 1;
      tick();
      push_a = 0;
      #1;
    end
    for (int i = 0; i < 6; i++) begin
      checks++; if (dout_a !== 8'(i + 1)) begin errors++; $display("FAIL b2b_head_%0d got %h want %h", i, dout_a, 8'(i + 1)); end
      din = 8'(i + 3); push_a = 1; pop_a = 1;
      tick();
      push_a = 0; pop_a = 0;
      #1;
      checks++; if (usage_a !== 2'd2) begin errors++; $display("FAIL b2b_usage_%0d got %0d want 2", i, usage_a); end
    end
    for (int i = 7; i <= 8; i++) begin
      checks++; if (dout_a !== 8'(i)) begin errors++; $display("FAIL b2b_tail_%0d got %h want %h", i, dout_a, 8'(i)); end
      pop_a = 1;
      tick();
      pop_a = 0;
      #1;
    end
    checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL b2b_empty got %b want 1", empty_a); end
    testmode = 0;
  endtask

  task automatic test_fall_through;
    do_reset();
    din = 8'hAA; push_f = 1; pop_f = 1;
    #1;
    checks++; if (dout_f !== 8'hAA) begin errors++; $display("FAIL ft_pass_data got %h want aa", dout_f); end
    tick();
    push_f = 0; pop_f = 0;
    #1;
    checks++; if (empty_f !== 1'b1) begin errors++; $display("FAIL ft_pass_empty got %b want 1", empty_f); end
    checks++; if (usage_f !== 2'd0) begin errors++; $display("FAIL ft_pass_usage got %0d want 0", usage_f); end
    din = 8'hBB; push_f = 1;
    #1;
    checks++; if (empty_f !== 1'b0) begin errors++; $display("FAIL ft_push_empty got %b want 0", empty_f); end
    checks++; if (dout_f !== 8'hBB) begin errors++; $display("FAIL ft_push_data got %h want bb", dout_f); end
    tick();
    push_f = 0; din = 8'h00;
    #1;
    checks++; if (usage_f !== 2'd1) begin errors++; $display("FAIL ft_stored_usage got %0d want 1", usage_f); end
    checks++; if (dout_f !== 8'hBB) begin errors++; $display("FAIL ft_stored_data got %h want bb", dout_f); end
    pop_f = 1;
    tick();
    pop_f = 0;
    #1;
    checks++; if (empty_f !== 1'b1) begin errors++; $display("FAIL ft_pop_empty got %b want 1", empty_f); end
  endtask

  task automatic test_flush;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      din = 8'hA1 + 8'(i); push_a = 1;
      tick();
      push_a = 0;
      #1;
    end
    checks++; if (usage_a !== 2'd3) begin errors++; $display("FAIL flush_pre_usage got %0d want 3", usage_a); end
    flush = 1; push_a = 1; din = 8'hA4;
    tick();
    flush = 0; push_a = 0;
    #1;
    checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL flush_empty got %b want 1", empty_a); end
    checks++; if (usage_a !== 2'd0) begin errors++; $display("FAIL flush_usage got %0d want 0", usage_a); end
    din = 8'h5A; push_a = 1;
    tick();
    push_a = 0;
    #1;
    checks++; if (dout_a !== 8'h5A) begin errors++; $display("FAIL flush_repush got %h want 5a", dout_a); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    din = 8'h66; push_a = 1;
    tick();
    din = 8'h77;
    tick();
    push_a = 0;
    rst = 1;
    #1;
    checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL midrst_empty got %b want 1", empty_a); end
    checks++; if (usage_a !== 2'd0) begin errors++; $display("FAIL midrst_usage got %0d want 0", usage_a); end
    checks++; if (dout_a !== 8'h00) begin errors++; $display("FAIL midrst_data got %h want 00", dout_a); end
    tick();
    rst = 0;
    #1;
  endtask

  task automatic test_non_pow2;
    logic [7:0] q [$];
    logic [7:0] nxt;
    logic [7:0] exp_d;
    do_reset();
    nxt = 8'h01;
    for (int r = 0; r < 10; r++) begin
      while (q.size() < 3) begin
        checks++; if (full_c !== 1'b0) begin errors++; $display("FAIL d3_notfull_r%0d got %b want 0", r, full_c); end
        din = nxt; push_c = 1; q.push_back(nxt); nxt = nxt + 8'd1;
        tick();
        push_c = 0;
        #1;
      end
      checks++; if (full_c !== 1'b1) begin errors++; $display("FAIL d3_full_r%0d got %b want 1", r, full_c); end
      checks++; if (usage_c !== 2'd3) begin errors++; $display("FAIL d3_usage_r%0d got %0d want 3", r, usage_c); end
      for (int k = 0; k < 2; k++) begin
        exp_d = q.pop_front();
        checks++; if (dout_c !== exp_d) begin errors++; $display("FAIL d3_order_r%0d_%0d got %h want %h", r, k, dout_c, exp_d); end
        pop_c = 1;
        tick();
        pop_c = 0;
        #1;
      end
    end
    exp_d = q.pop_front();
    checks++; if (dout_c !== exp_d) begin errors++; $display("FAIL d3_last got %h want %h", dout_c, exp_d); end
    pop_c = 1;
    tick();
    pop_c = 0;
    #1;
    checks++; if (empty_c !== 1'b1) begin errors++; $display("FAIL d3_empty got %b want 1", empty_c); end
  endtask

  task automatic test_passthru;
    do_reset();
    din = 8'hC3; push_p = 1; pop_p = 1;
    #1;
    checks++; if (dout_p !== 8'hC3) begin errors++; $display("FAIL pt_data got %h want c3", dout_p); end
    checks++; if (full_p !== 1'b0) begin errors++; $display("FAIL pt_full got %b want 0", full_p); end
    checks++; if (empty_p !== 1'b0) begin errors++; $display("FAIL pt_empty got %b want 0", empty_p); end
    checks++; if (usage_p !== 1'b0) begin errors++; $display("FAIL pt_usage got %0d want 0", usage_p); end
    push_p = 0; pop_p = 0;
    #1;
    checks++; if (empty_p !== 1'b1) begin errors++; $display("FAIL pt_idle_empty got %b want 1", empty_p); end
    checks++; if (full_p !== 1'b1) begin errors++; $display("FAIL pt_idle_full got %b want 1", full_p); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_fall_through();
    test_flush();
    test_reset_mid();
    test_non_pow2();
    test_passthru();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
